// File: rtl/sample_bist_ctrl.sv
// BIST controller for the 6-in/3-out `sample` block: LFSR stimulus, MISR response
// compaction, golden-signature check behind a start/busy/done handshake.
module sample_bist_ctrl #(
    parameter int unsigned PAT_COUNT  = 63,
    parameter logic [5:0]  LFSR_SEED  = 6'h01,
    parameter logic [7:0]  MISR_SEED  = 8'h00,
    parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [5:0] stim,
    input  logic [2:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature,
    output logic [9:0] pat_cnt
);

    localparam int unsigned LW = 6;
    localparam int unsigned SW = 8;
    localparam int unsigned CW = 10;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LW-1:0] SEED = (LFSR_SEED == '0) ? LW'(1) : LFSR_SEED;
    localparam logic [CW-1:0] LAST = CW'(PAT_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] lfsr_next_c;
    logic [SW-1:0] misr_next_c;

    // x^6+x^5+1 stimulus and x^8+x^4+x^3+x^2+1 signature steps.
    always_comb begin
        lfsr_next_c = {stim[4:0], stim[5] ^ stim[4]};
        misr_next_c = {signature[6:0], 1'b0}
                    ^ (signature[7] ? 8'h1D : 8'h00)
                    ^ {5'b0, resp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim      <= SEED;
            signature <= MISR_SEED;
            pat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        stim      <= SEED;
                        signature <= MISR_SEED;
                        pat_cnt   <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // signature and pat_cnt stay frozen for debug
                        stim  <= SEED;
                        pass  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        signature <= misr_next_c;
                        stim      <= lfsr_next_c;
                        pat_cnt   <= pat_cnt + CW'(1);
                        if (pat_cnt == LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        stim  <= SEED;
                        pass  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        pass  <= (signature == GOLDEN_SIG);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
